// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling, framing-error/break handling.
// Define UART_RX_PARITY_EN to expect one even-parity bit between bit 7 and the stop bit (8E1).
module uart_rx_core #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       perr,
  output logic       busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int HALF = CLK_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    sync_q, sync_d;
  logic          rxd_s;
  logic          bit_end;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  // sync_q[1] is the only copy of the line the rest of the logic may look at.
  assign sync_d  = {sync_q[0], rxd};
  assign rxd_s   = sync_q[1];
  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rxd_s};
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rxd_s) begin
            // Leaving half a bit early keeps back-to-back start edges catchable.
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= 2'b11;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync_q  <= sync_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign perr  = perr_q;
`else
  assign perr  = 1'b0;
`endif

  // A frame reports at most one outcome, and never in two adjacent cycles.
  assert property (@(posedge CLK) disable iff (reset) $onehot0({valid, ferr, perr}));
  assert property (@(posedge CLK) disable iff (reset)
    (valid || ferr || perr) |=> !(valid || ferr || perr));

endmodule
